sdram_frame_arbiter: RTL and testbench
======================================

# sdram_frame_arbiter

Parametrised SDRAM frame-buffer arbiter; successor to the single-camera/sobel SDRAM interface. It sits between `sdram_controller` and the pixel FIFOs. It schedules full-page burst writes from `NUM_WR` producer channels (raw camera, edge-detected, …) and full-page burst reads that refill the VGA FIFO. Frame buffers are optionally triple-buffered per channel so the display never reads a frame that is being written.

## Interface
- `NUM_WR`, 2: number of write (producer) channels, 1–4.
- `BURST_LEN`, 512: words per full-page burst.
- `PAGES_PER_FRAME`, 600: bursts per frame (640x480 / 512).
- `NUM_BUF`, 3: buffers per channel; legal values 1 (single buffer, no swap) or 3 (tear-free).
- `LEVEL_W`, 10: width of FIFO level inputs.
- `ADDR_W`, 15: controller page address width ({row, bank}).
- `RD_LOW_WATER`, 250: refill the read FIFO when its level is below this value.

Ports:
- `clk` in 1: controller clock; one clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_level` in NUM_WR*LEVEL_W: occupancy of each producer FIFO (channel c at bits [c*LEVEL_W +: LEVEL_W]).
- `wr_data` in NUM_WR*16: head word of each producer FIFO.
- `wr_pop` out NUM_WR: pop strobe for each producer FIFO.
- `rd_level` in LEVEL_W: write-side occupancy of the VGA FIFO.
- `rd_sel` in clog2(NUM_WR) (min 1): channel to display.
- `frame_done` out NUM_WR: one-cycle pulse when a channel completes a frame.
- `ctl_rw` out 1: 1 = read, 0 = write.
- `ctl_rw_en` out 1: command strobe.
- `ctl_addr` out ADDR_W: page address.
- `ctl_wdata` out 16: write data to the controller.
- `ctl_f2s_valid` in 1: controller is consuming a write word this cycle.
- `ctl_ready` in 1: controller is idle.

## Operation
- Region base = (c*NUM_BUF + b)*PAGES_PER_FRAME. `ctl_addr` = base + page. Parameter check: NUM_WR*NUM_BUF*PAGES_PER_FRAME ≤ 2^ADDR_W, otherwise elaboration error.
- Per write channel:
  - `wpage[c]` counts 0..PAGES_PER_FRAME-1.
  - `wbuf[c]` is the buffer being written.
  - `last[c]` is the most recently completed buffer.
- Read side:
  - `rpage` counts 0..PAGES_PER_FRAME-1.
  - `rch` and `rbuf` are latched when `rpage` = 0 and a read is issued: `rch` ← `rd_sel`, `rbuf` ← `last[rd_sel]`.
  - A change of `rd_sel` mid-frame takes effect only at the next frame start.
- Requests:
  - Read request: `rd_level` < RD_LOW_WATER.
  - Write request for channel c: `wr_level[c]` ≥ BURST_LEN.
- Arbitration order:
  1. Read request has top priority.
  2. Otherwise, round-robin among write requesters, starting after the last granted write channel.
  3. Reset pointer = channel 0.
- Write completion (last page), for channel c:
  - `wpage` wraps to 0 and `last[c]` ← `wbuf[c]`.
  - `frame_done[c]` pulses.
  - If NUM_BUF = 3, `wbuf[c]` ← the buffer that is neither the old `wbuf[c]` nor the buffer locked by the reader (lock applies only if `rch` = c). If NUM_BUF = 1, `wbuf` stays 0.
- Read completion (last page): `rpage` wraps to 0.
- Data path:
  - `ctl_wdata` = `wr_data` of the granted channel, combinationally from the grant register.
  - `wr_pop[g]` = `ctl_f2s_valid` & (current op is a write) & (grant = g). All other bits are 0.
- FSM states:
  - IDLE: if `ctl_ready` and any request, register grant, direction and address → CMD.
  - CMD: `ctl_rw_en` = 1 for exactly one cycle → WAIT.
  - WAIT: set the seen-low flag when `ctl_ready` = 0. Exit when `ctl_ready` = 1 and the flag is set; update counters/buffers → IDLE.
- Counters advance only on burst completion (WAIT exit), never at issue.

## Timing
- Reset values: `ctl_rw_en`=0, `ctl_rw`=0, `ctl_addr`=0, `wr_pop`=0, `frame_done`=0. Also all page counters 0, `wbuf[c]`=0, `last[c]`=0, `rbuf`=0, `rch`=0, state IDLE.
- Issue latency: request visible with `ctl_ready`=1 in IDLE → `ctl_rw_en` two edges later (IDLE→CMD→strobe).
- `ctl_addr`/`ctl_rw` are held stable from CMD until WAIT exit.
- Simultaneous requests: the read wins. A write starved by reads still wins the first arbitration in which no read request exists.
- Reset mid-burst: all state clears immediately. The controller is reset by the same `rst_n`.
- No overflow detection here. Producer FIFO depth must be ≥ 2*BURST_LEN.

## Structure
- Package `sdram_arb_pkg`: state enum (IDLE/CMD/WAIT) and a function `region_base(c, b)`.
- One sub-module, `rr_arbiter` (NUM_WR requests → grant index, pointer update on accept), reusable elsewhere.

## Test plan
- Reset, then `wr_level[0]`=520 with `rd_level`=600 → one write at `ctl_addr`=0, exactly 512 `wr_pop[0]` pulses aligned to `ctl_f2s_valid`.
- `wr_level[0]`=`wr_level[1]`=520 and `rd_level`=100, all together → read first (addr = base of ch0/buf0 page 0), then ch0, then ch1 (addr 1800 when NUM_BUF=3).
- Both channels held above 512 continuously → grants alternate 0,1,0,1. Neither channel gets two consecutive grants.
- Complete 600 pages on ch0 → `frame_done[0]` one pulse, `last[0]`=0, `wbuf[0]`=1. Next write goes to address 600.
- Reader locked on ch0 buf 1, writer finishes buf 2 → writer moves to buf 0, never buf 1.
- Toggle `rd_sel` 0→1 at read page 300 → pages 300–599 still come from ch0, page 0 of the next frame comes from `last[1]`.
- Assert `rst_n`=0 during WAIT → outputs return to reset values asynchronously. Next command is at address 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and address helpers for the SDRAM frame-buffer arbiter.
// Region layout: each channel owns NUM_BUF consecutive frame regions of PAGES_PER_FRAME pages.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WAIT} arb_state_t;

  function automatic int region_base(int c, int b, int num_buf, int pages);
    return (c * num_buf + b) * pages;
  endfunction

  // Lowest buffer index that is neither the one just written nor the one the reader holds.
  function automatic logic [1:0] next_wbuf(logic [1:0] old_buf, logic lock_en, logic [1:0] lock_buf);
    logic [1:0] pick;
    pick = 2'd0;
    for (int b = 2; b >= 0; b--) begin
      if (2'(b) != old_buf && !(lock_en && 2'(b) == lock_buf))
        pick = 2'(b);
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the channel after the last accepted grant.
// The pointer only moves when the grant is actually accepted.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_reg) + i) % N);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_reg <= '0;
    else if (accept)
      ptr_reg <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Schedules full-page burst writes from producer FIFOs and burst reads for the display FIFO,
// with optional triple buffering so the reader never sees a frame that is being written.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_WR          = 2,
  parameter int BURST_LEN       = 512,
  parameter int PAGES_PER_FRAME = 600,
  parameter int NUM_BUF         = 3,
  parameter int LEVEL_W         = 10,
  parameter int ADDR_W          = 15,
  parameter int RD_LOW_WATER    = 250,
  parameter int CW              = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_WR*LEVEL_W-1:0] wr_level,
  input  logic [NUM_WR*16-1:0]      wr_data,
  output logic [NUM_WR-1:0]         wr_pop,
  input  logic [LEVEL_W-1:0]        rd_level,
  input  logic [CW-1:0]             rd_sel,
  output logic [NUM_WR-1:0]         frame_done,
  output logic                      ctl_rw,
  output logic                      ctl_rw_en,
  output logic [ADDR_W-1:0]         ctl_addr,
  output logic [15:0]               ctl_wdata,
  input  logic                      ctl_f2s_valid,
  input  logic                      ctl_ready
);

  localparam int PW = (PAGES_PER_FRAME > 1) ? $clog2(PAGES_PER_FRAME) : 1;
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES_PER_FRAME - 1);

  if (NUM_WR * NUM_BUF * PAGES_PER_FRAME > 2 ** ADDR_W) begin : g_bad_size
    $error("sdram_frame_arbiter: frame regions exceed the page address space");
  end
  if (NUM_BUF != 1 && NUM_BUF != 3) begin : g_bad_buf
    $error("sdram_frame_arbiter: NUM_BUF must be 1 or 3");
  end

  arb_state_t          state_reg, state_next;
  logic [CW-1:0]       grant_reg;
  logic                op_rd_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                seen_low_reg;
  logic [PW-1:0]       rpage_reg;
  logic [CW-1:0]       rch_reg;
  logic [1:0]          rbuf_reg;
  logic [PW-1:0]       wpage_reg [NUM_WR];
  logic [1:0]          wbuf_reg  [NUM_WR];
  logic [1:0]          last_reg  [NUM_WR];
  logic [NUM_WR-1:0]   frame_done_reg;
  logic [15:0]         wr_word   [NUM_WR];

  logic                rd_req, wr_any, issue, issue_wr, burst_done;
  logic [NUM_WR-1:0]   wr_req;
  logic [CW-1:0]       arb_grant, rd_ch;
  logic [1:0]          rd_buf;
  logic [ADDR_W-1:0]   issue_addr;

  assign rd_req     = rd_level < LEVEL_W'(RD_LOW_WATER);
  assign issue      = (state_reg == IDLE) && ctl_ready && (rd_req || wr_any);
  assign issue_wr   = issue && !rd_req;
  assign burst_done = (state_reg == WAIT) && ctl_ready && seen_low_reg;

  rr_arbiter #(.N(NUM_WR), .IW(CW)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .accept  (issue_wr),
    .grant   (arb_grant),
    .any_req (wr_any)
  );

  // The display channel/buffer is only re-chosen at page 0 of a read frame.
  always_comb begin
    rd_ch  = (rpage_reg == '0) ? rd_sel : rch_reg;
    rd_buf = (rpage_reg == '0) ? last_reg[rd_sel] : rbuf_reg;
    if (rd_req)
      issue_addr = ADDR_W'(region_base(int'(rd_ch), int'(rd_buf), NUM_BUF, PAGES_PER_FRAME)
                           + int'(rpage_reg));
    else
      issue_addr = ADDR_W'(region_base(int'(arb_grant), int'(wbuf_reg[arb_grant]), NUM_BUF,
                                       PAGES_PER_FRAME) + int'(wpage_reg[arb_grant]));
  end

  always_comb begin
    state_next = state_reg;
    ctl_rw_en  = 1'b0;
    case (state_reg)
      IDLE: if (issue) state_next = CMD;
      CMD: begin
        ctl_rw_en  = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      op_rd_reg    <= 1'b0;
      addr_reg     <= '0;
      seen_low_reg <= 1'b0;
      rpage_reg    <= '0;
      rch_reg      <= '0;
      rbuf_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        grant_reg    <= arb_grant;
        op_rd_reg    <= rd_req;
        addr_reg     <= issue_addr;
        seen_low_reg <= 1'b0;
        if (rd_req && rpage_reg == '0) begin
          rch_reg  <= rd_sel;
          rbuf_reg <= last_reg[rd_sel];
        end
      end
      if (state_reg == WAIT && !ctl_ready)
        seen_low_reg <= 1'b1;
      if (burst_done && op_rd_reg)
        rpage_reg <= (rpage_reg == LAST_PAGE) ? '0 : rpage_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_ch
    logic ch_done, page_wrap;

    assign wr_word[gi] = wr_data[gi*16 +: 16];
    assign wr_req[gi]  = 32'(wr_level[gi*LEVEL_W +: LEVEL_W]) >= BURST_LEN;
    assign wr_pop[gi]  = ctl_f2s_valid && !op_rd_reg && (state_reg != IDLE)
                         && (grant_reg == CW'(gi));
    assign ch_done     = burst_done && !op_rd_reg && (grant_reg == CW'(gi));
    assign page_wrap   = wpage_reg[gi] == LAST_PAGE;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wpage_reg[gi]      <= '0;
        wbuf_reg[gi]       <= '0;
        last_reg[gi]       <= '0;
        frame_done_reg[gi] <= 1'b0;
      end else begin
        frame_done_reg[gi] <= ch_done && page_wrap;
        if (ch_done) begin
          if (page_wrap) begin
            wpage_reg[gi] <= '0;
            last_reg[gi]  <= wbuf_reg[gi];
            wbuf_reg[gi]  <= (NUM_BUF == 3)
                             ? next_wbuf(wbuf_reg[gi], rch_reg == CW'(gi), rbuf_reg) : 2'd0;
          end else begin
            wpage_reg[gi] <= wpage_reg[gi] + 1'b1;
          end
        end
      end
    end
  end

  assign ctl_rw     = op_rd_reg;
  assign ctl_addr   = addr_reg;
  assign ctl_wdata  = wr_word[grant_reg];
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Scoreboard bench: expected commands are queued by the stimulus, a negedge monitor checks
// every command, pop strobe, write word and frame_done pulse against a simple controller model.
module tb_sdram_frame_arbiter;

  localparam int NW = 2, BL = 16, PPF = 8, NB = 3, LW = 10, AW = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NW*LW-1:0] wr_level;
  logic [NW*16-1:0] wr_data;
  logic [NW-1:0]   wr_pop;
  logic [LW-1:0]   rd_level;
  logic [0:0]      rd_sel;
  logic [NW-1:0]   frame_done;
  logic            ctl_rw, ctl_rw_en, ctl_f2s_valid, ctl_ready;
  logic [AW-1:0]   ctl_addr;
  logic [15:0]     ctl_wdata;

  always #5 clk = ~clk;

  sdram_frame_arbiter #(
    .NUM_WR(NW), .BURST_LEN(BL), .PAGES_PER_FRAME(PPF), .NUM_BUF(NB),
    .LEVEL_W(LW), .ADDR_W(AW), .RD_LOW_WATER(250)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_level(wr_level), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_level(rd_level), .rd_sel(rd_sel), .frame_done(frame_done), .ctl_rw(ctl_rw),
    .ctl_rw_en(ctl_rw_en), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_f2s_valid(ctl_f2s_valid), .ctl_ready(ctl_ready)
  );

  // Controller model: busy for BL cycles after a strobe, streaming f2s_valid on writes.
  int  c_cnt;
  logic c_wr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_ready     <= 1'b1;
      ctl_f2s_valid <= 1'b0;
      c_cnt         <= 0;
      c_wr          <= 1'b0;
    end else if (ctl_ready && ctl_rw_en) begin
      ctl_ready <= 1'b0;
      c_cnt     <= BL;
      c_wr      <= !ctl_rw;
    end else if (!ctl_ready) begin
      if (c_cnt > 0) begin
        c_cnt         <= c_cnt - 1;
        ctl_f2s_valid <= c_wr;
      end else begin
        ctl_f2s_valid <= 1'b0;
        ctl_ready     <= 1'b1;
      end
    end
  end

  typedef struct {logic rw; int addr; int ch;} cmd_t;
  cmd_t exp_q[$];
  int checks = 0, errors = 0, cmd_count = 0;
  int fd_cnt[NW];
  bit in_burst = 0;

  function automatic logic [15:0] word_of(int c);
    return (c == 0) ? 16'h1234 : 16'hBEEF;
  endfunction

  task automatic expw(input int c, input int b, input int p);
    cmd_t e;
    e.rw = 1'b0; e.addr = (c * NB + b) * PPF + p; e.ch = c;
    exp_q.push_back(e);
  endtask

  task automatic expr(input int a);
    cmd_t e;
    e.rw = 1'b1; e.addr = a; e.ch = 0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor
  initial begin
    cmd_t e;
    logic [NW-1:0] pop_exp;
    bit cur_wr, seen_busy;
    int cur_ch, pop_cnt;
    cur_wr = 0; seen_busy = 0; cur_ch = 0; pop_cnt = 0;
    fd_cnt[0] = 0; fd_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_burst = 0;
        seen_busy = 0;
      end else begin
        if (ctl_rw_en) begin
          cmd_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected got rw=%0d addr=%0d required none", ctl_rw, ctl_addr);
            cur_wr = !ctl_rw; cur_ch = 0;
          end else begin
            e = exp_q.pop_front();
            if (ctl_rw !== e.rw || ctl_addr !== AW'(e.addr)) begin
              errors++;
              $display("FAIL cmd%0d got rw=%0d addr=%0d required rw=%0d addr=%0d",
                       cmd_count, ctl_rw, ctl_addr, e.rw, e.addr);
            end else begin
              $display("cmd%0d rw=%0d addr=%0d ok", cmd_count, ctl_rw, ctl_addr);
            end
            cur_wr = !e.rw; cur_ch = e.ch;
          end
          in_burst = 1; seen_busy = 0; pop_cnt = 0;
        end
        pop_exp = (in_burst && cur_wr && ctl_f2s_valid) ? NW'(1 << cur_ch) : '0;
        checks++;
        if (wr_pop !== pop_exp) begin
          errors++;
          $display("FAIL wr_pop got %b required %b", wr_pop, pop_exp);
        end
        if (wr_pop != '0) begin
          pop_cnt++;
          checks++;
          if (ctl_wdata !== word_of(cur_ch)) begin
            errors++;
            $display("FAIL wdata got %h required %h", ctl_wdata, word_of(cur_ch));
          end
        end
        for (int c = 0; c < NW; c++) if (frame_done[c]) fd_cnt[c]++;
        if (in_burst) begin
          if (!ctl_ready) seen_busy = 1;
          else if (seen_busy) begin
            in_burst = 0;
            if (cur_wr) begin
              checks++;
              if (pop_cnt != BL) begin
                errors++;
                $display("FAIL pop_count got %0d required %0d", pop_cnt, BL);
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_cmds(input int target);
    int t;
    t = 0;
    while (cmd_count < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (cmd_count < target) begin
      checks++; errors++;
      $display("FAIL cmd_timeout got %0d required %0d", cmd_count, target);
    end
  endtask

  task automatic settle();
    int t;
    t = 0;
    while (in_burst && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (in_burst) begin
      checks++; errors++;
      $display("FAIL burst_timeout got busy required idle");
    end
    repeat (3) @(posedge clk);
  endtask

  // Hold the given requests until n more commands are issued, then drop them and let the burst end.
  task automatic run(input bit w0, input bit w1, input bit rdl, input int n);
    int target;
    target   = cmd_count + n;
    wr_level = {(w1 ? 10'd520 : 10'd0), (w0 ? 10'd520 : 10'd0)};
    rd_level = rdl ? 10'd100 : 10'd600;
    wait_cmds(target);
    wr_level = '0;
    rd_level = 10'd600;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_level = '0;
    wr_data  = {16'hBEEF, 16'h1234};
    rd_level = 10'd600;
    rd_sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rw_en", 32'(ctl_rw_en), 0);
    chk("rst_rw", 32'(ctl_rw), 0);
    chk("rst_addr", 32'(ctl_addr), 0);
    chk("rst_pop", 32'(wr_pop), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    @(negedge clk) rst_n = 1'b1;

    // single write on ch0
    expw(0, 0, 0);
    run(1, 0, 0, 1);
    // read wins a simultaneous request, then round robin resumes after ch0
    expr(0);
    run(1, 1, 1, 1);
    expw(1, 0, 0); expw(0, 0, 1);
    run(1, 1, 0, 2);
    // both held: strict alternation
    expw(1, 0, 1); expw(0, 0, 2); expw(1, 0, 2); expw(0, 0, 3);
    run(1, 1, 0, 4);
    // reads starve writes, the write wins once reads stop
    expr(1); expr(2);
    run(1, 1, 1, 2);
    expw(1, 0, 3);
    run(1, 1, 0, 1);
    // ch0 completes a frame and moves to buffer 1
    expw(0, 0, 4); expw(0, 0, 5); expw(0, 0, 6); expw(0, 0, 7); expw(0, 1, 0);
    run(1, 0, 0, 5);
    chk("fd0_after_frame", 32'(fd_cnt[0]), 1);
    // rd_sel change mid-frame is deferred to the next frame start
    expr(3); expr(4);
    run(0, 0, 1, 2);
    rd_sel = 1'b1;
    expr(5); expr(6); expr(7);
    run(0, 0, 1, 3);
    for (int p = 4; p < PPF; p++) expw(1, 0, p);
    run(0, 1, 0, 4);
    for (int p = 0; p < PPF; p++) expw(1, 1, p);
    run(0, 1, 0, 8);
    chk("fd1_two_frames", 32'(fd_cnt[1]), 2);
    expr(32);
    run(0, 0, 1, 1);
    // reader now locked on ch1 buf1: writer goes 0 -> 2 -> 0, never 1
    for (int p = 0; p < PPF; p++) expw(1, 0, p);
    run(0, 1, 0, 8);
    for (int p = 0; p < PPF; p++) expw(1, 2, p);
    run(0, 1, 0, 8);
    expw(1, 0, 0);
    run(0, 1, 0, 1);
    chk("fd1_four_frames", 32'(fd_cnt[1]), 4);
    chk("fd0_unchanged", 32'(fd_cnt[0]), 1);

    // asynchronous reset in the middle of a write burst
    expw(0, 1, 1);
    wr_level = {10'd0, 10'd520};
    wait_cmds(cmd_count + 1);
    wr_level = '0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rw_en", 32'(ctl_rw_en), 0);
    chk("midrst_addr", 32'(ctl_addr), 0);
    chk("midrst_pop", 32'(wr_pop), 0);
    chk("midrst_rw", 32'(ctl_rw), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    expw(0, 0, 0);
    run(1, 0, 0, 1);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
